// File: rtl/vending_machine_multi.sv
// Multi-coin vending controller: accumulates credit, vends at PRICE, returns change, refunds on cancel.
// Latency: coin reaching PRICE at edge N -> dispensed in cycle N+1 -> change_valid in cycle N+2.
// Backpressure: none; coins that cannot be taken are dropped and flagged by a coin_reject pulse.
//
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   coin[1:0]         : 00 none, 01/10/11 = COIN_A/COIN_B/COIN_C, sampled every edge
//   cancel            : refund accumulated credit (acted on only while accumulating)
//   restock           : reload stock to STOCK_MAX (acted on only when idle)
//   dispensed         : one-cycle pulse, one item released
//   change_valid      : one-cycle pulse qualifying change_amt
//   change_amt        : change or refund value, holds between pulses
//   credit            : current accumulated credit
//   stock, sold_out   : items remaining, high when stock is zero
//   coin_reject       : one-cycle pulse, previous-edge coin was dropped
module vending_machine_multi #(
  parameter int PRICE     = 15,
  parameter int COIN_A    = 5,
  parameter int COIN_B    = 10,
  parameter int COIN_C    = 25,
  parameter int CREDIT_W  = 6,
  parameter int STOCK_MAX = 3,
  parameter int STOCK_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispensed,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out,
  output logic                coin_reject
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] VAL_A      = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] VAL_B      = CREDIT_W'(COIN_B);
  localparam logic [CREDIT_W-1:0] VAL_C      = CREDIT_W'(COIN_C);
  localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_MAX);

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  // Amount owed back after the current vend; only meaningful in VEND.
  logic [CREDIT_W-1:0] change_due;
  logic [CREDIT_W-1:0] change_due_nxt;
  logic [CREDIT_W-1:0] change_amt_nxt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] coin_sum;
  logic [STOCK_W-1:0]  stock_nxt;
  logic                dispensed_nxt;
  logic                change_valid_nxt;
  logic                coin_reject_nxt;
  logic                sold_out_nxt;
  logic                coin_present;
  logic                restock_now;
  logic                cancel_now;
  logic                coin_open;
  logic                coin_take;

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = VAL_A;
      2'b10:   coin_val = VAL_B;
      2'b11:   coin_val = VAL_C;
      default: coin_val = '0;
    endcase
  end

  assign coin_present = (coin != 2'b00);
  assign coin_sum     = credit + coin_val;
  assign restock_now  = (state == ST_IDLE) && restock;
  assign cancel_now   = (state == ST_ACCUM) && cancel;

  // A simultaneous restock lifts the sold-out lock for the coin on the same edge.
  assign coin_open = ((state == ST_IDLE) || (state == ST_ACCUM)) &&
                     !(sold_out && !restock_now) && !cancel_now;
  assign coin_take = coin_present && coin_open;

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    change_due_nxt   = change_due;
    change_amt_nxt   = change_amt;
    stock_nxt        = stock;
    dispensed_nxt    = 1'b0;
    change_valid_nxt = 1'b0;
    coin_reject_nxt  = coin_present && !coin_take;

    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (restock_now) begin
          stock_nxt = STOCK_FULL;
        end
        if (cancel_now) begin
          state_nxt        = ST_REFUND;
          credit_nxt       = '0;
          change_valid_nxt = 1'b1;
          change_amt_nxt   = credit;
        end else if (coin_take) begin
          if (coin_sum >= PRICE_C) begin
            // Credit is cleared on entry to VEND; the overshoot is kept for CHANGE.
            state_nxt      = ST_VEND;
            credit_nxt     = '0;
            change_due_nxt = coin_sum - PRICE_C;
            dispensed_nxt  = 1'b1;
          end else begin
            state_nxt  = ST_ACCUM;
            credit_nxt = coin_sum;
          end
        end
      end

      ST_VEND: begin
        credit_nxt = '0;
        if (stock != '0) begin
          stock_nxt = stock - STOCK_W'(1);
        end
        if (change_due != '0) begin
          state_nxt        = ST_CHANGE;
          change_valid_nxt = 1'b1;
          change_amt_nxt   = change_due;
        end else begin
          state_nxt = ST_IDLE;
        end
        change_due_nxt = '0;
      end

      ST_CHANGE: begin
        state_nxt = ST_IDLE;
      end

      ST_REFUND: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        // Unreachable encodings recover to a clean idle with no credit.
        state_nxt      = ST_IDLE;
        credit_nxt     = '0;
        change_due_nxt = '0;
      end
    endcase

    sold_out_nxt = (stock_nxt == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      change_due   <= '0;
      stock        <= STOCK_FULL;
      dispensed    <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      change_due   <= change_due_nxt;
      stock        <= stock_nxt;
      dispensed    <= dispensed_nxt;
      change_valid <= change_valid_nxt;
      change_amt   <= change_amt_nxt;
      coin_reject  <= coin_reject_nxt;
      sold_out     <= sold_out_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
module tb_vending_machine_multi;

  localparam int PRICE     = 15;
  localparam int COIN_A    = 5;
  localparam int COIN_B    = 10;
  localparam int COIN_C    = 25;
  localparam int CREDIT_W  = 6;
  localparam int STOCK_MAX = 3;
  localparam int STOCK_W   = 4;

  localparam int F_DISP = 1;
  localparam int F_CV   = 2;
  localparam int F_REJ  = 4;

  logic                clock;
  logic                reset;
  logic [1:0]          coin;
  logic                cancel;
  logic                restock;
  logic                dispensed;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;
  logic                coin_reject;

  vending_machine_multi #(
    .PRICE(PRICE), .COIN_A(COIN_A), .COIN_B(COIN_B), .COIN_C(COIN_C),
    .CREDIT_W(CREDIT_W), .STOCK_MAX(STOCK_MAX), .STOCK_W(STOCK_W)
  ) dut (
    .clock(clock), .reset(reset), .coin(coin), .cancel(cancel), .restock(restock),
    .dispensed(dispensed), .change_valid(change_valid), .change_amt(change_amt),
    .credit(credit), .stock(stock), .sold_out(sold_out), .coin_reject(coin_reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    bit disp;
    bit cv;
    int amt;
    bit rej;
  } ev_t;

  typedef struct {
    int cyc;
    int credit;
    int stock;
    bit sold;
  } st_t;

  ev_t evq[$];
  st_t stq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit running = 1'b0;

  // Reference model: machine is either open (credit 0 or accumulating) or busy
  // finishing a transaction up to and including edge busy_edge.
  int m_credit;
  int m_stock;
  int busy_edge;
  int dec_edge;
  int ev_flags[int];
  int ev_amt[int];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int coin_value(input int c);
    case (c)
      1:       return COIN_A;
      2:       return COIN_B;
      3:       return COIN_C;
      default: return 0;
    endcase
  endfunction

  function automatic void add_ev(input int c, input int flag, input int amt);
    if (!ev_flags.exists(c)) ev_flags[c] = 0;
    ev_flags[c] = ev_flags[c] | flag;
    if (flag == F_CV) ev_amt[c] = amt;
  endfunction

  function automatic void model_reset();
    m_credit  = 0;
    m_stock   = STOCK_MAX;
    busy_edge = -1;
    dec_edge  = -1;
    ev_flags.delete();
    ev_amt.delete();
  endfunction

  // Apply edge n with the given inputs; outputs land in cycle n.
  function automatic void model_edge(input int n, input int c, input bit can, input bit rs);
    int sum;
    ev_t e;
    st_t s;
    if (dec_edge == n) m_stock = m_stock - 1;
    if (n <= busy_edge) begin
      if (c != 0) add_ev(n, F_REJ, 0);
    end else begin
      if (rs && m_credit == 0) m_stock = STOCK_MAX;
      if (can && m_credit > 0) begin
        add_ev(n, F_CV, m_credit);
        m_credit  = 0;
        busy_edge = n + 1;
        if (c != 0) add_ev(n, F_REJ, 0);
      end else if (c != 0) begin
        if (m_stock == 0) begin
          add_ev(n, F_REJ, 0);
        end else begin
          sum = m_credit + coin_value(c);
          if (sum >= PRICE) begin
            add_ev(n, F_DISP, 0);
            dec_edge = n + 1;
            if (sum > PRICE) begin
              add_ev(n + 1, F_CV, sum - PRICE);
              busy_edge = n + 2;
            end else begin
              busy_edge = n + 1;
            end
            m_credit = 0;
          end else begin
            m_credit = sum;
          end
        end
      end
    end
    s.cyc = n; s.credit = m_credit; s.stock = m_stock; s.sold = (m_stock == 0);
    stq.push_back(s);
    if (ev_flags.exists(n)) begin
      e.cyc  = n;
      e.disp = (ev_flags[n] & F_DISP) != 0;
      e.cv   = (ev_flags[n] & F_CV) != 0;
      e.rej  = (ev_flags[n] & F_REJ) != 0;
      e.amt  = ev_amt.exists(n) ? ev_amt[n] : 0;
      evq.push_back(e);
      ev_flags.delete(n);
      if (ev_amt.exists(n)) ev_amt.delete(n);
    end
  endfunction

  task automatic step(input int c, input bit can, input bit rs);
    coin    = 2'(c);
    cancel  = can;
    restock = rs;
    @(posedge clock);
    #1;
    cyc++;
    model_edge(cyc, c, can, rs);
    coin    = 2'b00;
    cancel  = 1'b0;
    restock = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_stock", int'(stock), STOCK_MAX);
    chk("rst_sold_out", int'(sold_out), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_dispensed", int'(dispensed), 0);
    chk("rst_coin_reject", int'(coin_reject), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: per-cycle status plus pulse events popped from the scoreboard.
  always @(negedge clock) begin
    if (!reset && running) begin
      if (stq.size() == 0) begin
        total++; bad++;
        $display("FAIL status_missing cyc=%0d got=none want=entry", cyc);
      end else begin
        st_t s;
        s = stq.pop_front();
        chk("status_cycle", cyc, s.cyc);
        chk("credit", int'(credit), s.credit);
        chk("stock", int'(stock), s.stock);
        chk("sold_out", int'(sold_out), int'(s.sold));
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL event_missed cyc=%0d got=none want_cyc=%0d", cyc, evq[0].cyc);
        void'(evq.pop_front());
      end
      if (dispensed || change_valid || coin_reject) begin
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL event_unexpected cyc=%0d got=d%0d/c%0d/r%0d want=none",
                   cyc, dispensed, change_valid, coin_reject);
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("dispensed", int'(dispensed), int'(e.disp));
          chk("change_valid", int'(change_valid), int'(e.cv));
          chk("coin_reject", int'(coin_reject), int'(e.rej));
          if (e.cv) chk("change_amt", int'(change_amt), e.amt);
        end
      end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
        total++; bad++;
        $display("FAIL event_absent cyc=%0d got=none want=d%0d/c%0d/r%0d",
                 cyc, evq[0].disp, evq[0].cv, evq[0].rej);
        void'(evq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    coin    = 2'b00;
    cancel  = 1'b0;
    restock = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("init_credit", int'(credit), 0);
    chk("init_stock", int'(stock), STOCK_MAX);
    chk("init_sold_out", int'(sold_out), 0);
    chk("init_dispensed", int'(dispensed), 0);
    chk("init_change_valid", int'(change_valid), 0);
    chk("init_change_amt", int'(change_amt), 0);
    chk("init_coin_reject", int'(coin_reject), 0);
    reset   = 1'b0;
    running = 1'b1;

    // Exact price from three small coins.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); idle(2);
    // Overshoot with a gap between coins.
    step(2, 0, 0); step(0, 0, 0); step(2, 0, 0); idle(3);
    // Single large coin from idle.
    step(3, 0, 0); idle(3);
    // Stock is now empty: coin rejected, then restock.
    step(1, 0, 0); step(0, 0, 1); idle(1);
    // Cancel with a simultaneous coin.
    step(1, 0, 0); step(2, 1, 0); idle(2);
    // Cancel and restock with no credit are ignored / harmless.
    step(0, 1, 0); step(1, 0, 1); step(0, 0, 1); step(2, 0, 0); idle(2);
    // Drain stock, hit sold-out, then restock together with a coin.
    step(2, 0, 0); step(1, 0, 0); idle(2);
    step(1, 0, 0); step(2, 0, 0); idle(2);
    step(3, 0, 0); idle(3);
    step(1, 0, 0); idle(1);
    step(1, 0, 1); step(2, 0, 0); idle(3);
    // Coins during VEND/CHANGE are rejected.
    step(3, 0, 0); step(1, 0, 0); step(2, 0, 0); idle(2);
    // Reset mid-cycle while accumulating.
    step(2, 0, 0);
    mid_reset();
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      int c;
      bit can;
      bit rs;
      c   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      can = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) mid_reset();
      step(c, can, rs);
    end
    idle(4);
    @(negedge clock);
    #1;
    if (evq.size() != 0) begin
      total++; bad++;
      $display("FAIL events_left cyc=%0d got=%0d want=0", cyc, evq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parameterised successor to the single-price coin FSM.
- Accepts three configurable coin denominations and dispenses at a configurable price.
- Returns change, supports cancel/refund, and tracks item stock with sold-out lock-out.
- Sits between the coin-acceptor decoder and the dispense/change-return actuators. All outputs are registered.

Parameters:
- PRICE, 15: item price in credit units; must be ≥1.
- COIN_A, 5: value of coin code 2'b01.
- COIN_B, 10: value of coin code 2'b10.
- COIN_C, 25: value of coin code 2'b11.
- CREDIT_W, 6: credit/change width; must hold PRICE-1+max(COIN_*).
- STOCK_MAX, 3: stock count loaded on reset and on restock; must be ≥1.
- STOCK_W, 4: stock counter width; must hold STOCK_MAX.

Ports:
- clock, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- coin, input, 2: 00 = none, 01/10/11 = COIN_A/B/C; sampled every edge.
- cancel, input, 1: request refund of the accumulated credit.
- restock, input, 1: reload stock to STOCK_MAX.
- dispensed, output, 1: one-cycle pulse; one item released.
- change_valid, output, 1: one-cycle pulse; change_amt is valid.
- change_amt, output, CREDIT_W: change or refund value, qualified by change_valid.
- credit, output, CREDIT_W: current accumulated credit.
- stock, output, STOCK_W: items remaining.
- sold_out, output, 1: high when stock==0.
- coin_reject, output, 1: one-cycle pulse; the coin sampled on the previous edge was not accepted.

Behaviour:
- Reset (async, any state): state=IDLE, credit=0, stock=STOCK_MAX. dispensed, change_valid, coin_reject=0; change_amt=0; sold_out=0. Credit held at reset is lost; no refund is issued.
- States: IDLE (credit==0), ACCUM (0<credit<PRICE), VEND, CHANGE, REFUND. Encoded in 3 bits; illegal encodings go to IDLE with credit=0.
- Coin acceptance happens only in IDLE/ACCUM with sold_out=0. The coin value is added to credit at the sampling edge.
- Coins arriving in VEND/CHANGE/REFUND, while sold_out=1, or in the same cycle as a cancel that is acted on are discarded. For these, coin_reject is high for the following cycle.
- A coin with credit+value < PRICE goes to (or stays in) ACCUM.
- A coin with credit+value ≥ PRICE goes to VEND, and the sum is held in an internal total.
- VEND lasts exactly one cycle:
  - dispensed=1 and stock decrements by 1.
  - If total-PRICE > 0, the next state is CHANGE with change_amt = total-PRICE.
  - Otherwise the next state is IDLE.
  - credit reads 0 from VEND onward.
- Latency: the coin that reaches PRICE is sampled at edge N. dispensed is high for the cycle after edge N. change_valid is high the cycle after that.
- CHANGE lasts one cycle: change_valid=1, then the next state is IDLE.
- Cancel in ACCUM (coin ignored if simultaneous) goes to REFUND. REFUND lasts one cycle: change_valid=1, change_amt = credit before cancel, credit=0, then the next state is IDLE.
- Cancel in IDLE, VEND, CHANGE or REFUND: no effect.
- change_amt holds its last value when change_valid=0.
- restock is honoured only in IDLE: stock=STOCK_MAX at the next edge. It is ignored in other states.
- restock and coin together in IDLE: both take effect. The coin is accepted even if stock was 0 before the edge (restock wins the sold-out check).
- Stock reaches 0 after a VEND, so sold_out=1 from the next cycle. sold_out=1 in IDLE rejects all coins until restock.
- No arithmetic overflow is possible given the width constraints. Credit never exceeds PRICE-1 outside VEND.

Test Plan (defaults):
- coin 01,01,01 on consecutive edges → credit 5,10 then dispensed pulse; change_valid stays 0; stock 3→2.
- coin 10, idle cycle, coin 10 → dispensed pulse, next cycle change_valid=1 with change_amt=5; credit=0.
- single coin 11 from IDLE → dispensed, then change_valid with change_amt=10; state returns to IDLE within 3 cycles.
- coin 01, then cancel together with coin 10 → change_valid with change_amt=5, coin_reject pulse, credit=0, no dispense.
- three 15-credit vends → stock=0, sold_out=1; next coin 01 → coin_reject, credit stays 0. Then restock → stock=3, sold_out=0.
- credit=10 (ACCUM), assert reset mid-cycle → credit=0, state IDLE immediately, no change_valid pulse, stock=3.
